vpu_lane_seq: RTL and testbench
===============================

VPU_LANE_SEQ -- requirements
Module: VPU_LANE_SEQ

Interface
REQ-001 SHALL have parameter NUM_FU, default 8, meaning number of attached functional units (FP add/sub, mul, div, max, avg, sqrt, exp, recip order).
REQ-002 SHALL have parameter OPERAND_WIDTH, default 32, meaning operand/result width in bits.
REQ-003 SHALL have parameter SRC_CNT, default 3, meaning source operands per request.
REQ-004 SHALL have parameter DEPTH, default 4, meaning in-order result buffer entries; power of two, at least 2.
REQ-005 SHALL have port clk  input  1  the single clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port req_valid_i  input  1  request valid.
REQ-008 SHALL have port req_ready_o  output  1  request accepted when both high.
REQ-009 SHALL have port req_fu_i  input  NUM_FU  one-hot target unit select.
REQ-010 SHALL have port req_operand_i  input  SRC_CNT x OPERAND_WIDTH  source operands.
REQ-011 SHALL have port req_operand_valid_i  input  SRC_CNT  per-operand valid mask.
REQ-012 SHALL have port fu_start_o  output  NUM_FU  one-cycle start pulse per unit.
REQ-013 SHALL have port fu_operand_o  output  SRC_CNT x OPERAND_WIDTH  registered operands, broadcast to all units.
REQ-014 SHALL have port fu_operand_valid_o  output  SRC_CNT  registered operand valid mask.
REQ-015 SHALL have port fu_done_i  input  NUM_FU  per-unit completion pulse.
REQ-016 SHALL have port fu_result_i  input  NUM_FU x OPERAND_WIDTH  per-unit result, sampled with done.
REQ-017 SHALL have port rsp_valid_o  output  1  head result available.
REQ-018 SHALL have port rsp_ready_i  input  1  consumer accepts result.
REQ-019 SHALL have port rsp_data_o  output  OPERAND_WIDTH  result data.
REQ-020 SHALL have port rsp_err_o  output  1  request had non-one-hot req_fu_i.
REQ-021 SHALL have port occupancy_o  output  clog2(DEPTH)+1  buffer entries in use.

Function
REQ-022 req_ready_o SHALL be high iff occupancy < DEPTH and (req_fu_i not one-hot or busy[k]=0 for selected unit k); no same-cycle bypass from retirement.
REQ-023 On acceptance, SHALL allocate the tail entry, record unit index k there and tail tag in fu_tag[k], set busy[k], and register operands/mask.
REQ-024 fu_start_o[k] SHALL pulse exactly one cycle, the cycle after acceptance, with fu_operand_o/fu_operand_valid_o stable that cycle.
REQ-025 fu_done_i[k] with busy[k]=1 SHALL write fu_result_i[k] into entry fu_tag[k], mark it complete and clear busy[k] at that edge; done with busy[k]=0 SHALL be ignored.
REQ-026 Non-one-hot req_fu_i (zero or multiple bits) SHALL allocate an entry marked complete with data 0 and error flag, issue no start pulse, set no busy bit.
REQ-027 rsp_valid_o SHALL equal completion flag of head entry; rsp_data_o/rsp_err_o SHALL reflect head entry.
REQ-028 rsp_valid_o and rsp_ready_i high SHALL retire head: clear its flags, advance head pointer.
REQ-029 Results SHALL retire strictly in acceptance order regardless of unit completion order.
REQ-030 Minimum latency: accept at cycle 0, start at 1, done at 1+L, rsp_valid_o at 2+L; error request rsp_valid_o at cycle 1 if at head.
REQ-031 Accept and retire in same cycle SHALL leave occupancy unchanged; head/tail pointers SHALL wrap modulo DEPTH.
REQ-032 Multiple fu_done_i bits in one cycle SHALL all be captured.

Reset
REQ-033 While rst_n low: req_ready_o=0 is not required; fu_start_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, occupancy_o=0, all busy, completion flags and pointers 0, registered operands 0.
REQ-034 Reset mid-operation SHALL discard all entries; later fu_done_i pulses SHALL be ignored per REQ-025.

Structure
REQ-035 Default parameter values and response struct (data, err) SHALL live in VPU_PKG.
REQ-036 Result buffer SHALL be one sub-module, VPU_LANE_ROB (alloc/complete/retire ports, tag-addressed write).

Verification
REQ-037 Single mul (req_fu_i=8'h02, ops 3F800000/40000000), model L=3 returning 40000000 -> start on fu 1 at cycle 1, rsp_valid at cycle 5, data 40000000, err 0.
REQ-038 Div (L=10) then add (L=2), back-to-back -> add done first, responses div then add in order.
REQ-039 Four requests to four units, rsp_ready_i=0 -> occupancy 4, req_ready_o=0; raise rsp_ready_i -> four retirements, occupancy 0, pointer wrap.
REQ-040 Second request to busy unit -> req_ready_o=0 until cycle after its done.
REQ-041 req_fu_i=8'h00 and 8'h03 -> no start pulse, rsp_err_o=1, rsp_data_o=0.
REQ-042 rst_n low while two ops outstanding, stale fu_done_i after release -> rsp_valid_o stays 0, occupancy_o 0.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared defaults and response type for the vector lane sequencer.
package vpu_pkg;

    localparam int unsigned NumFuDefault        = 8;
    localparam int unsigned OperandWidthDefault = 32;
    localparam int unsigned SrcCntDefault       = 3;
    localparam int unsigned DepthDefault        = 4;

    typedef struct packed {
        logic [OperandWidthDefault-1:0] data;
        logic                           err;
    } vpu_rsp_t;

endpackage

// File: rtl/vpu_lane_rob.sv
// In-order result buffer: allocate at tail, tag-addressed completion writes, retire from head.
module vpu_lane_rob
    import vpu_pkg::*;
#(
    parameter int unsigned DEPTH  = DepthDefault,
    parameter int unsigned WIDTH  = OperandWidthDefault,
    parameter int unsigned NUM_WR = NumFuDefault,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_i,
    input  logic                         alloc_err_i,
    output logic [PtrW-1:0]              tail_o,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR-1:0][PtrW-1:0]  wr_tag_i,
    input  logic [NUM_WR-1:0][WIDTH-1:0] wr_data_i,
    input  logic                         retire_i,
    output logic                         head_done_o,
    output logic [WIDTH-1:0]             head_data_o,
    output logic                         head_err_o,
    output logic [CntW-1:0]              count_o
);

    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] err_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PtrW-1:0]  head_q, tail_q;
    logic [CntW-1:0]  count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= '0;
            err_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                data_q[e] <= '0;
            end
        end else begin
            // A completion always targets an occupied, incomplete entry, so it never
            // collides with the tail being allocated or the head being retired.
            for (int unsigned e = 0; e < DEPTH; e++) begin
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (wr_en_i[w] && (wr_tag_i[w] == PtrW'(e))) begin
                        done_q[e] <= 1'b1;
                        data_q[e] <= wr_data_i[w];
                    end
                end
            end
            if (alloc_i) begin
                done_q[tail_q] <= alloc_err_i;
                err_q[tail_q]  <= alloc_err_i;
                data_q[tail_q] <= '0;
                tail_q         <= tail_q + PtrW'(1);
            end
            if (retire_i) begin
                done_q[head_q] <= 1'b0;
                err_q[head_q]  <= 1'b0;
                data_q[head_q] <= '0;
                head_q         <= head_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(alloc_i) - CntW'(retire_i);
        end
    end

    assign tail_o      = tail_q;
    assign head_done_o = done_q[head_q];
    assign head_data_o = data_q[head_q];
    assign head_err_o  = err_q[head_q];
    assign count_o     = count_q;

endmodule

// File: rtl/vpu_lane_seq.sv
// Vector lane sequencer: dispatches requests to one-hot selected units, collects results in order.
module vpu_lane_seq
    import vpu_pkg::*;
#(
    parameter int unsigned NUM_FU        = NumFuDefault,
    parameter int unsigned OPERAND_WIDTH = OperandWidthDefault,
    parameter int unsigned SRC_CNT       = SrcCntDefault,
    parameter int unsigned DEPTH         = DepthDefault
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [NUM_FU-1:0]                     req_fu_i,
    input  logic [SRC_CNT-1:0][OPERAND_WIDTH-1:0] req_operand_i,
    input  logic [SRC_CNT-1:0]                    req_operand_valid_i,
    output logic [NUM_FU-1:0]                     fu_start_o,
    output logic [SRC_CNT-1:0][OPERAND_WIDTH-1:0] fu_operand_o,
    output logic [SRC_CNT-1:0]                    fu_operand_valid_o,
    input  logic [NUM_FU-1:0]                     fu_done_i,
    input  logic [NUM_FU-1:0][OPERAND_WIDTH-1:0]  fu_result_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [OPERAND_WIDTH-1:0]              rsp_data_o,
    output logic                                  rsp_err_o,
    output logic [$clog2(DEPTH):0]                occupancy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [NUM_FU-1:0]                     busy_q, busy_d;
    logic [NUM_FU-1:0]                     start_q, start_d;
    logic [NUM_FU-1:0]                     done_hit;
    logic [NUM_FU-1:0][PtrW-1:0]           fu_tag_q;
    logic [SRC_CNT-1:0][OPERAND_WIDTH-1:0] operand_q;
    logic [SRC_CNT-1:0]                    operand_valid_q;
    logic [PtrW-1:0]                       tail;
    logic                                  head_done;
    logic                                  fu_onehot, unit_free, accept, issue, retire;

    always_comb begin
        fu_onehot   = $onehot(req_fu_i);
        unit_free   = ((req_fu_i & busy_q) == '0);
        // Ready looks only at registered occupancy: no bypass from a same-cycle retire.
        req_ready_o = (occupancy_o < CntW'(DEPTH)) && (!fu_onehot || unit_free);
        accept      = req_valid_i && req_ready_o;
        issue       = accept && fu_onehot;
        done_hit    = fu_done_i & busy_q;
        retire      = head_done && rsp_ready_i;
        start_d     = issue ? req_fu_i : '0;
        busy_d      = (busy_q & ~done_hit) | start_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q          <= '0;
            start_q         <= '0;
            fu_tag_q        <= '0;
            operand_q       <= '0;
            operand_valid_q <= '0;
        end else begin
            busy_q  <= busy_d;
            start_q <= start_d;
            if (accept) begin
                operand_q       <= req_operand_i;
                operand_valid_q <= req_operand_valid_i;
            end
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                if (start_d[k]) begin
                    fu_tag_q[k] <= tail;
                end
            end
        end
    end

    assign fu_start_o         = start_q;
    assign fu_operand_o       = operand_q;
    assign fu_operand_valid_o = operand_valid_q;
    assign rsp_valid_o        = head_done;

    vpu_lane_rob #(
        .DEPTH  (DEPTH),
        .WIDTH  (OPERAND_WIDTH),
        .NUM_WR (NUM_FU)
    ) u_rob (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_i     (accept),
        .alloc_err_i (!fu_onehot),
        .tail_o      (tail),
        .wr_en_i     (done_hit),
        .wr_tag_i    (fu_tag_q),
        .wr_data_i   (fu_result_i),
        .retire_i    (retire),
        .head_done_o (head_done),
        .head_data_o (rsp_data_o),
        .head_err_o  (rsp_err_o),
        .count_o     (occupancy_o)
    );

endmodule

// File: tb/tb_vpu_lane_seq.sv
// Scoreboard bench for vpu_lane_seq with behavioural functional-unit models.
module tb_vpu_lane_seq;

    localparam int unsigned NF = 8;
    localparam int unsigned W  = 32;
    localparam int unsigned SC = 3;
    localparam int unsigned D  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [NF-1:0]        req_fu = '0;
    logic [SC-1:0][W-1:0] req_operand = '0;
    logic [SC-1:0]        req_operand_valid = '0;
    logic [NF-1:0]        fu_start;
    logic [SC-1:0][W-1:0] fu_operand;
    logic [SC-1:0]        fu_operand_valid;
    logic [NF-1:0]        fu_done = '0;
    logic [NF-1:0][W-1:0] fu_result = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [W-1:0]         rsp_data;
    logic                 rsp_err;
    logic [$clog2(D):0]   occupancy;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    vpu_lane_seq #(
        .NUM_FU        (NF),
        .OPERAND_WIDTH (W),
        .SRC_CNT       (SC),
        .DEPTH         (D)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid_i         (req_valid),
        .req_ready_o         (req_ready),
        .req_fu_i            (req_fu),
        .req_operand_i       (req_operand),
        .req_operand_valid_i (req_operand_valid),
        .fu_start_o          (fu_start),
        .fu_operand_o        (fu_operand),
        .fu_operand_valid_o  (fu_operand_valid),
        .fu_done_i           (fu_done),
        .fu_result_i         (fu_result),
        .rsp_valid_o         (rsp_valid),
        .rsp_ready_i         (rsp_ready),
        .rsp_data_o          (rsp_data),
        .rsp_err_o           (rsp_err),
        .occupancy_o         (occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // What each attached unit computes; mul of 1.0 by x returns x.
    function automatic logic [W-1:0] fu_calc(input int k, input logic [SC-1:0][W-1:0] ops);
        if (k == 1 && ops[0] == 32'h3F80_0000) return ops[1];
        return (ops[0] + ops[1]) ^ ops[2] ^ (32'(k) << 24);
    endfunction

    // Functional-unit models: latch on start, pulse done after lat[k] cycles.
    int           lat [NF];
    int           cnt [NF];
    logic [W-1:0] pend [NF];

    initial begin
        for (int k = 0; k < NF; k++) begin
            cnt[k] = 0;
            pend[k] = '0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NF; k++) begin
                if (fu_start[k]) begin
                    cnt[k] = lat[k];
                    pend[k] = fu_calc(k, fu_operand);
                end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < NF; k++) begin
                fu_done[k] = 1'b0;
                if (cnt[k] > 0) begin
                    cnt[k] = cnt[k] - 1;
                    if (cnt[k] == 0) begin
                        fu_done[k] = 1'b1;
                        fu_result[k] = pend[k];
                    end
                end
            end
        end
    end

    int rdy_mode = 1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: list of outstanding requests in acceptance order.
    typedef struct {
        int           unit;
        logic         err;
        logic         done;
        logic [W-1:0] data;
    } ent_t;

    ent_t                 sb [$];
    ent_t                 mon_e;
    logic [NF-1:0]        m_busy = '0;
    logic [NF-1:0]        m_exp_start = '0;
    logic [SC-1:0][W-1:0] m_exp_ops = '0;
    logic [SC-1:0]        m_exp_mask = '0;
    logic                 exp_v, exp_rdy;
    int                   sel;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_busy = '0;
            m_exp_start = '0;
            check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            check("rst_rsp_data", 64'(rsp_data), 64'(0));
            check("rst_rsp_err", 64'(rsp_err), 64'(0));
            check("rst_occupancy", 64'(occupancy), 64'(0));
            check("rst_fu_start", 64'(fu_start), 64'(0));
            check("rst_fu_operand", 64'(fu_operand[0] | fu_operand[1] | fu_operand[2]), 64'(0));
        end else begin
            check("occupancy", 64'(occupancy), 64'(sb.size()));
            exp_v = 1'b0;
            if (sb.size() > 0) exp_v = sb[0].done;
            check("rsp_valid", 64'(rsp_valid), 64'(exp_v));

            sel = -1;
            if ($countones(req_fu) == 1) begin
                for (int k = 0; k < NF; k++) if (req_fu[k]) sel = k;
            end
            exp_rdy = (sb.size() < D) && (sel < 0 || !m_busy[sel]);
            if (req_valid) check("req_ready", 64'(req_ready), 64'(exp_rdy));

            if (fu_start != '0 || m_exp_start != '0) begin
                check("fu_start", 64'(fu_start), 64'(m_exp_start));
                if (m_exp_start != '0) begin
                    check("fu_operand0", 64'(fu_operand[0]), 64'(m_exp_ops[0]));
                    check("fu_operand2", 64'(fu_operand[2]), 64'(m_exp_ops[2]));
                    check("fu_operand_valid", 64'(fu_operand_valid), 64'(m_exp_mask));
                end
            end

            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("retire_from_empty", 64'(0), 64'(1));
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                    check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                end
            end

            for (int k = 0; k < NF; k++) begin
                if (fu_done[k] && m_busy[k]) begin
                    m_busy[k] = 1'b0;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (sb[i].unit == k && !sb[i].done) sb[i].done = 1'b1;
                    end
                end
            end

            m_exp_start = '0;
            if (req_valid && req_ready) begin
                if (sel >= 0) begin
                    sb.push_back('{sel, 1'b0, 1'b0, fu_calc(sel, req_operand)});
                    m_busy[sel] = 1'b1;
                    m_exp_start = req_fu;
                    m_exp_ops = req_operand;
                    m_exp_mask = req_operand_valid;
                end else begin
                    sb.push_back('{-1, 1'b1, 1'b1, '0});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [NF-1:0] fu, input logic [SC-1:0][W-1:0] ops,
                         input logic [SC-1:0] mask, output int acc);
        int n;
        n = 0;
        acc = -1;
        req_fu = fu;
        req_operand = ops;
        req_operand_valid = mask;
        req_valid = 1'b1;
        while (acc < 0) begin
            @(negedge clk);
            if (req_ready) acc = cyc;
            @(posedge clk);
            #1;
            n++;
            if (acc < 0 && n > 300) begin
                check("issue_timeout", 64'(0), 64'(1));
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int c, output logic [W-1:0] d, output logic e);
        c = -1;
        d = '0;
        e = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                c = cyc;
                d = rsp_data;
                e = rsp_err;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [SC-1:0][W-1:0] ops;
    logic [W-1:0]         rd;
    logic                 re;
    int                   a, a2, c, i0, j0;
    logic [NF-1:0]        fsel;

    initial begin
        for (int k = 0; k < NF; k++) lat[k] = k + 1;
        rdy_mode = 1;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Single mul, L=3.
        lat[1] = 3;
        ops[0] = 32'h3F80_0000;
        ops[1] = 32'h4000_0000;
        ops[2] = '0;
        issue(8'h02, ops, 3'b011, a);
        wait_rsp(c, rd, re);
        check("mul_latency", 64'(c - a), 64'(5));
        check("mul_data", 64'(rd), 64'(32'h4000_0000));
        check("mul_err", 64'(re), 64'(0));
        idle(3);

        // Non-one-hot selects complete immediately with an error.
        ops[0] = 32'h1234_5678;
        issue(8'h00, ops, 3'b111, a);
        wait_rsp(c, rd, re);
        check("err00_latency", 64'(c - a), 64'(1));
        check("err00_flag", 64'(re), 64'(1));
        check("err00_data", 64'(rd), 64'(0));
        issue(8'h03, ops, 3'b111, a);
        wait_rsp(c, rd, re);
        check("err03_flag", 64'(re), 64'(1));
        check("err03_data", 64'(rd), 64'(0));
        idle(2);

        // Slow div then fast add: add completes first, responses stay in order.
        lat[2] = 10;
        lat[0] = 2;
        ops[0] = 32'h4120_0000;
        ops[1] = 32'h4000_0000;
        issue(8'h04, ops, 3'b011, a);
        ops[0] = 32'h3F00_0000;
        issue(8'h01, ops, 3'b011, a);
        idle(16);

        // Second request to a busy unit waits for its done.
        lat[3] = 6;
        issue(8'h08, ops, 3'b001, a);
        issue(8'h08, ops, 3'b010, a2);
        check("busy_gap", 64'(a2 - a), 64'(2 + 6));
        idle(10);

        // Fill the buffer with the consumer stalled, then drain.
        rdy_mode = 0;
        idle(1);
        for (int k = 4; k < 8; k++) begin
            ops[0] = 32'(k * 17);
            issue(NF'(1) << k, ops, 3'b111, a);
        end
        idle(12);
        req_fu = 8'h01;
        @(negedge clk);
        check("full_occupancy", 64'(occupancy), 64'(4));
        check("full_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        rdy_mode = 1;
        idle(8);
        @(negedge clk);
        check("drained_occupancy", 64'(occupancy), 64'(0));
        @(posedge clk);
        #1;

        // Reset with two operations in flight; their late dones must be dropped.
        lat[2] = 10;
        lat[6] = 12;
        issue(8'h04, ops, 3'b111, a);
        issue(8'h40, ops, 3'b111, a);
        idle(2);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
            check("post_rst_occupancy", 64'(occupancy), 64'(0));
        end
        @(posedge clk);
        #1;

        // Randomised traffic with a random consumer.
        rdy_mode = 2;
        for (int k = 0; k < NF; k++) lat[k] = int'($urandom_range(1, 8));
        for (int n = 0; n < 250; n++) begin
            i0 = int'($urandom_range(0, 9));
            if (i0 < 8) begin
                fsel = NF'(1) << $urandom_range(0, NF - 1);
            end else if (i0 == 8) begin
                fsel = '0;
            end else begin
                i0 = int'($urandom_range(0, NF - 1));
                j0 = (i0 + 1 + int'($urandom_range(0, NF - 2))) % NF;
                fsel = (NF'(1) << i0) | (NF'(1) << j0);
            end
            for (int s = 0; s < SC; s++) ops[s] = $urandom;
            issue(fsel, ops, SC'($urandom_range(0, 7)), a);
            idle(int'($urandom_range(0, 2)));
        end
        rdy_mode = 1;
        idle(30);
        @(negedge clk);
        check("final_occupancy", 64'(occupancy), 64'(0));
        check("final_rsp_valid", 64'(rsp_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
